instruction_fetch_decode: RTL and testbench
===========================================

INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 16'd0, program-counter value loaded on reset.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 oAddress  output  16  instruction address to the instruction ROM; equals the PC register.
REQ-005 iInstruction  input  28  instruction word returned combinationally by the ROM for oAddress.
REQ-006 iStall  input  1  downstream not ready; hold PC and decode outputs.
REQ-007 iBranchTaken  input  1  redirect fetch to iBranchTarget.
REQ-008 iBranchTarget  input  16  redirect address.
REQ-009 oValid  output  1  decode outputs hold a valid instruction.
REQ-010 oOperation  output  4  iInstruction[27:24] of the latched word.
REQ-011 oDestination  output  8  iInstruction[23:16] of the latched word.
REQ-012 oSourceAddr1  output  8  iInstruction[15:8] of the latched word.
REQ-013 oSourceAddr0  output  8  iInstruction[7:0] of the latched word.
REQ-014 oImmediate  output  16  iInstruction[15:0] of the latched word; same bits as {oSourceAddr1,oSourceAddr0}.
REQ-015 oPC  output  16  address the latched word was fetched from.

Function
REQ-016 Two-state FSM: ST_BOOT (one cycle after Reset release; PC held, oValid=0; ROM settles) then ST_RUN; there is no path back to ST_BOOT except Reset.
REQ-017 ST_RUN, iStall=0, iBranchTaken=0: latch iInstruction fields and oPC<=PC, set oValid=1, PC<=PC+1; one-cycle fetch-to-decode latency.
REQ-018 PC increment wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-019 iStall=1, iBranchTaken=0: PC, decode fields, oPC and oValid all hold.
REQ-020 iBranchTaken=1 in ST_RUN: PC<=iBranchTarget, oValid<=0 (one bubble), decode fields hold; branch wins over iStall.
REQ-021 iBranchTaken in ST_BOOT is ignored.
REQ-022 Next valid instruction after a branch is the word at iBranchTarget, one cycle after redirect (absent stall).
REQ-023 No decode of opcode semantics; opcode value is passed through unchanged.

Reset
REQ-024 Reset has priority over every input and applies mid-stall or mid-branch.
REQ-025 Reset values: PC=RESET_PC, state=ST_BOOT, oValid=0, oOperation/oDestination/oSourceAddr1/oSourceAddr0=0, oPC=0.

Configuration
REQ-026 Macro FETCH_PERF_COUNT_EN: when defined, adds output oFetchCount (16 bits), reset to 0, incremented by 1 on every cycle oValid is newly set per REQ-017, wrapping at 16'hFFFF; when undefined, port and counter are absent and all other behaviour is identical.

Verification
REQ-027 Reset 3 cycles, release, iStall=0 -> oValid=0 for the boot cycle, then oPC=0,1,2,... on successive cycles with fields matching the ROM word per address.
REQ-028 ROM word {4'h5,8'h05,8'h04,8'h03} at address 5 -> oOperation=4'h5, oDestination=8'h05, oSourceAddr1=8'h04, oSourceAddr0=8'h03, oPC=5.
REQ-029 iStall=1 for 3 cycles at PC=3 -> oAddress stays 3, outputs frozen; on release the next oPC=3.
REQ-030 iBranchTaken=1, iBranchTarget=16'h0100, iStall=1 same cycle -> next cycle oValid=0 and oAddress=16'h0100; the following cycle oPC=16'h0100.
REQ-031 Load PC=16'hFFFF via branch -> oPC=16'hFFFF then 16'h0000; with FETCH_PERF_COUNT_EN, oFetchCount increments once per valid instruction and is 0 after Reset.
REQ-032 Reset asserted while oValid=1 and iStall=1 -> next cycle all outputs at reset values and oAddress=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode front end: drives the instruction ROM address, registers the returned word into
// decode fields, and supports stall and branch redirect. Optional FETCH_PERF_COUNT_EN adds oFetchCount.
module instruction_fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic        oValid,
    output logic [3:0]  oOperation,
    output logic [7:0]  oDestination,
    output logic [7:0]  oSourceAddr1,
    output logic [7:0]  oSourceAddr0,
    output logic [15:0] oImmediate,
    output logic [15:0] oPC,
`ifdef FETCH_PERF_COUNT_EN
    output logic [15:0] oFetchCount,
`endif
    output logic        oDebugState
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  dst_q, dst_d;
    logic [7:0]  src1_q, src1_d;
    logic [7:0]  src0_q, src0_d;
    logic [15:0] opc_q, opc_d;
    logic        fetch_fire;

    // Handshake: a fetch is accepted in ST_RUN whenever iStall is low and no branch is
    // redirecting; a branch in ST_RUN always wins and inserts exactly one bubble.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        op_d       = op_q;
        dst_d      = dst_q;
        src1_d     = src1_q;
        src0_d     = src0_q;
        opc_d      = opc_q;
        fetch_fire = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (iBranchTaken) begin
                    pc_d    = iBranchTarget;
                    valid_d = 1'b0;
                end else if (!iStall) begin
                    fetch_fire = 1'b1;
                    op_d       = iInstruction[27:24];
                    dst_d      = iInstruction[23:16];
                    src1_d     = iInstruction[15:8];
                    src0_d     = iInstruction[7:0];
                    opc_d      = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            op_q    <= '0;
            dst_q   <= '0;
            src1_q  <= '0;
            src0_q  <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src1_q  <= src1_d;
            src0_q  <= src0_d;
            opc_q   <= opc_d;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (fetch_fire) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oFetchCount = count_q;
`else
    logic unused_fetch_fire;
    assign unused_fetch_fire = fetch_fire;
`endif

    assign oAddress     = pc_q;
    assign oValid       = valid_q;
    assign oOperation   = op_q;
    assign oDestination = dst_q;
    assign oSourceAddr1 = src1_q;
    assign oSourceAddr0 = src0_q;
    assign oImmediate   = {src1_q, src0_q};
    assign oPC          = opc_q;
    assign oDebugState  = state_q;

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Bench for instruction_fetch_decode: directed steps plus random stall/branch/reset traffic
// checked against a cycle-level reference model of the fetch rules.
module tb_instruction_fetch_decode;

    localparam logic [15:0] RESET_PC = 16'd0;

    logic        Clock;
    logic        Reset;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic        oValid;
    logic [3:0]  oOperation;
    logic [7:0]  oDestination;
    logic [7:0]  oSourceAddr1;
    logic [7:0]  oSourceAddr0;
    logic [15:0] oImmediate;
    logic [15:0] oPC;
    logic        oDebugState;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] oFetchCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_boot;
    logic        m_valid;
    logic [27:0] m_word;
    logic [15:0] m_opc;
    logic [15:0] m_count;

    instruction_fetch_decode #(.RESET_PC(RESET_PC)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oAddress     (oAddress),
        .iInstruction (iInstruction),
        .iStall       (iStall),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oValid       (oValid),
        .oOperation   (oOperation),
        .oDestination (oDestination),
        .oSourceAddr1 (oSourceAddr1),
        .oSourceAddr0 (oSourceAddr0),
        .oImmediate   (oImmediate),
        .oPC          (oPC),
`ifdef FETCH_PERF_COUNT_EN
        .oFetchCount  (oFetchCount),
`endif
        .oDebugState  (oDebugState)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] rom_word(input logic [15:0] a);
        logic [27:0] w;
        if (a == 16'd5) begin
            w = {4'h5, 8'h05, 8'h04, 8'h03};
        end else begin
            w = {a[3:0] ^ a[15:12] ^ 4'h9, a[7:0] ^ 8'hA5, a[15:8] + a[3:0], a[7:0] + 8'h3C};
        end
        return w;
    endfunction

    assign iInstruction = rom_word(oAddress);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_addr"},  {16'd0, oAddress},     {16'd0, m_pc});
        chk({tag, "_valid"}, {31'd0, oValid},       {31'd0, m_valid});
        chk({tag, "_op"},    {28'd0, oOperation},   {28'd0, m_word[27:24]});
        chk({tag, "_dst"},   {24'd0, oDestination}, {24'd0, m_word[23:16]});
        chk({tag, "_src1"},  {24'd0, oSourceAddr1}, {24'd0, m_word[15:8]});
        chk({tag, "_src0"},  {24'd0, oSourceAddr0}, {24'd0, m_word[7:0]});
        chk({tag, "_imm"},   {16'd0, oImmediate},   {16'd0, m_word[15:0]});
        chk({tag, "_pc"},    {16'd0, oPC},          {16'd0, m_opc});
        chk({tag, "_boot"},  {31'd0, oDebugState},  {31'd0, ~m_boot});
`ifdef FETCH_PERF_COUNT_EN
        chk({tag, "_cnt"},   {16'd0, oFetchCount},  {16'd0, m_count});
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic br, input logic [15:0] tgt);
        Reset         = rst;
        iStall        = st;
        iBranchTaken  = br;
        iBranchTarget = tgt;
        @(posedge Clock);
        if (rst) begin
            m_pc    = RESET_PC;
            m_boot  = 1'b1;
            m_valid = 1'b0;
            m_word  = '0;
            m_opc   = '0;
            m_count = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (br) begin
            m_pc    = tgt;
            m_valid = 1'b0;
        end else if (!st) begin
            m_word  = rom_word(m_pc);
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 16'd1;
            m_count = m_count + 16'd1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        m_pc = '0; m_boot = 1'b1; m_valid = 1'b0; m_word = '0; m_opc = '0; m_count = '0;
        Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;

        // Three reset cycles, then the boot bubble, then sequential fetch from 0
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b0, 16'h0);
        step("boot", 1'b0, 1'b0, 1'b1, 16'h1234);
        chk("boot_valid", {31'd0, oValid}, 32'd0);
        chk("boot_addr", {16'd0, oAddress}, {16'd0, RESET_PC});
        for (int i = 0; i < 8; i++) begin
            step("seq", 1'b0, 1'b0, 1'b0, 16'h0);
            chk("seq_opc", {16'd0, oPC}, i);
            if (i == 5) begin
                chk("rom5_op",   {28'd0, oOperation},   32'h5);
                chk("rom5_dst",  {24'd0, oDestination}, 32'h05);
                chk("rom5_src1", {24'd0, oSourceAddr1}, 32'h04);
                chk("rom5_src0", {24'd0, oSourceAddr0}, 32'h03);
            end
        end

        // Stall three cycles at PC=3, then release
        step("br3", 1'b0, 1'b0, 1'b1, 16'd3);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b0, 1'b1, 1'b0, 16'h0);
            chk("stall_addr", {16'd0, oAddress}, 32'd3);
        end
        step("unstall", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("unstall_opc", {16'd0, oPC}, 32'd3);

        // Branch together with stall: branch wins
        step("br_stall", 1'b0, 1'b1, 1'b1, 16'h0100);
        chk("br_stall_valid", {31'd0, oValid}, 32'd0);
        chk("br_stall_addr", {16'd0, oAddress}, 32'h0100);
        step("br_tgt", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("br_tgt_opc", {16'd0, oPC}, 32'h0100);

        // PC wrap
        step("br_ffff", 1'b0, 1'b0, 1'b1, 16'hFFFF);
        step("wrap0", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap_opc_ffff", {16'd0, oPC}, 32'hFFFF);
        step("wrap1", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap_opc_0000", {16'd0, oPC}, 32'h0000);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                             : 16'($urandom_range(0, 65535)));
        end

        // Reset while valid and stalled
        step("pre_rst_a", 1'b0, 1'b0, 1'b0, 16'h0);
        step("pre_rst_b", 1'b0, 1'b0, 1'b0, 16'h0);
        step("pre_rst_c", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("pre_rst_valid", {31'd0, oValid}, 32'd1);
        step("rst_stall", 1'b1, 1'b1, 1'b1, 16'h00AA);
        chk("rst_valid", {31'd0, oValid}, 32'd0);
        chk("rst_addr", {16'd0, oAddress}, {16'd0, RESET_PC});
        chk("rst_opc", {16'd0, oPC}, 32'd0);
        chk("rst_op", {28'd0, oOperation}, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("rst_cnt", {16'd0, oFetchCount}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
